// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter that lets two requesters share one
// SPI master, one byte transaction at a time.
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without m_done (done pulse with err=1).
module spi_txn_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  input  logic [1:0] mode0_i,
  input  logic [1:0] mode1_i,
  output logic       gnt0_o,
  output logic       gnt1_o,
  output logic       done0_o,
  output logic       done1_o,
  output logic [7:0] rx_data_o,
  output logic       err_o,
  output logic       m_start_o,
  output logic [7:0] m_data_o,
  output logic       m_polarity_o,
  output logic       m_phase_o,
  input  logic       m_busy_i,
  input  logic       m_done_i,
  input  logic [7:0] m_rx_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t     state_q;
  logic       last_q;     // 1: requester 1 was served last
  logic       owner_q;    // 1: requester 1 owns the current transaction
  logic       gnt0_q, gnt1_q, done0_q, done1_q, m_start_q;
  logic [7:0] m_data_q, rx_data_q;
  logic       m_pol_q, m_pha_q;
  logic       pick1;

  // Requester 1 wins when it asks alone, or on a tie when requester 0 went last.
  assign pick1 = req1_i & (~req0_i | ~last_q);

`ifdef SPI_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;
  logic       expire;

  // Expiry is seen on the last allowed WAIT cycle so DONE lands TIMEOUT_CYCLES after WAIT entry.
  assign expire = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign err_o  = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err_o          = 1'b0;
`endif

  // Sequencer: arbitrate, present byte/mode, kick the master, wait, report.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      m_start_q <= 1'b0;
      m_data_q  <= 8'h00;
      rx_data_q <= 8'h00;
      m_pol_q   <= 1'b0;
      m_pha_q   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q     <= 8'h00;
      err_q     <= 1'b0;
`endif
    end else begin
      m_start_q <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (!m_busy_i && (req0_i || req1_i)) begin
            owner_q  <= pick1;
            gnt0_q   <= ~pick1;
            gnt1_q   <= pick1;
            m_data_q <= pick1 ? data1_i : data0_i;
            m_pol_q  <= pick1 ? mode1_i[1] : mode0_i[1];
            m_pha_q  <= pick1 ? mode1_i[0] : mode0_i[0];
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          m_start_q <= 1'b1;
          state_q   <= S_START;
        end
        S_START: begin
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_q   <= 8'h00;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (m_done_i) begin
            rx_data_q <= m_rx_i;
            done0_q   <= ~owner_q;
            done1_q   <= owner_q;
            state_q   <= S_DONE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (expire) begin
            err_q   <= 1'b1;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        S_DONE: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          last_q  <= owner_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt0_o       = gnt0_q;
  assign gnt1_o       = gnt1_q;
  assign done0_o      = done0_q;
  assign done1_o      = done1_q;
  assign m_start_o    = m_start_q;
  assign m_data_o     = m_data_q;
  assign m_polarity_o = m_pol_q;
  assign m_phase_o    = m_pha_q;
  assign rx_data_o    = rx_data_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: directed vector table, hand-written corner
// sequences (busy hold-off, stray m_done, mid-transaction reset, timeout)
// and randomized transactions against a transaction-level model.
module tb_spi_txn_arbiter;

  localparam int TB_TO = 10;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int LONG_DLY = 8;
`else
  localparam int LONG_DLY = 15;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       req0_i, req1_i;
  logic [7:0] data0_i, data1_i;
  logic [1:0] mode0_i, mode1_i;
  logic       gnt0_o, gnt1_o, done0_o, done1_o, err_o, m_start_o;
  logic [7:0] rx_data_o, m_data_o;
  logic       m_polarity_o, m_phase_o;
  logic       m_busy_i, m_done_i;
  logic [7:0] m_rx_i;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state
  bit         last_w1 = 1'b1;
  logic [7:0] exp_rx  = 8'h00;

  spi_txn_arbiter #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req0_i(req0_i), .req1_i(req1_i),
    .data0_i(data0_i), .data1_i(data1_i),
    .mode0_i(mode0_i), .mode1_i(mode1_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
    .done0_o(done0_o), .done1_o(done1_o),
    .rx_data_o(rx_data_o), .err_o(err_o),
    .m_start_o(m_start_o), .m_data_o(m_data_o),
    .m_polarity_o(m_polarity_o), .m_phase_o(m_phase_o),
    .m_busy_i(m_busy_i), .m_done_i(m_done_i), .m_rx_i(m_rx_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         r0, r1;
    logic [7:0] d0, d1;
    logic [1:0] md0, md1;
    int         dly;
    logic [7:0] rx;
    bit         drop;
    bit         w1;
    logic [7:0] md;
    bit         pol, pha;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_cycle(input string tag, input bit g0, input bit g1,
                              input bit dn0, input bit dn1, input bit e, input bit st);
    chk1({tag, ".gnt0"}, gnt0_o, g0);
    chk1({tag, ".gnt1"}, gnt1_o, g1);
    chk1({tag, ".done0"}, done0_o, dn0);
    chk1({tag, ".done1"}, done1_o, dn1);
    chk1({tag, ".err"}, err_o, e);
    chk1({tag, ".m_start"}, m_start_o, st);
  endtask

  task automatic chk_bus(input string tag, input logic [7:0] md, input bit pol, input bit pha);
    chk8({tag, ".m_data"}, m_data_o, md);
    chk1({tag, ".m_polarity"}, m_polarity_o, pol);
    chk1({tag, ".m_phase"}, m_phase_o, pha);
  endtask

  task automatic chk_reset(input string tag);
    expect_cycle(tag, 0, 0, 0, 0, 0, 0);
    chk_bus(tag, 8'h00, 0, 0);
    chk8({tag, ".rx_data"}, rx_data_o, 8'h00);
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle after DONE.
  task automatic run_txn(input bit r0, input bit r1, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] md0, input logic [1:0] md1,
                         input bit w1, input logic [7:0] md, input bit pol, input bit pha,
                         input int dly, input logic [7:0] rx, input bit drop, input bit to_exp);
    int n;
    req0_i = r0; req1_i = r1;
    data0_i = d0; data1_i = d1; mode0_i = md0; mode1_i = md1;
    tick();
    // latched values must not follow the inputs after the grant
    data0_i = 8'($urandom); data1_i = 8'($urandom);
    mode0_i = 2'($urandom); mode1_i = 2'($urandom);
    if (drop) begin
      req0_i = 1'b0; req1_i = 1'b0;
    end
    expect_cycle("setup", !w1, w1, 0, 0, 0, 0);
    chk_bus("setup", md, pol, pha);
    tick();
    expect_cycle("start", !w1, w1, 0, 0, 0, 1);
    chk_bus("start", md, pol, pha);
    n = to_exp ? TB_TO : dly + 1;
    for (int i = 0; i < n; i++) begin
      m_rx_i = 8'($urandom);
      tick();
      expect_cycle("wait", !w1, w1, 0, 0, 0, 0);
      chk_bus("wait", md, pol, pha);
    end
    if (!to_exp) begin
      m_done_i = 1'b1;
      m_rx_i   = rx;
      exp_rx   = rx;
    end
    tick();
    m_done_i = 1'b0;
    m_rx_i   = 8'($urandom);
    expect_cycle(to_exp ? "tmo_done" : "done", !w1, w1, !w1, w1, to_exp, 0);
    chk_bus("done", md, pol, pha);
    chk8("done.rx_data", rx_data_o, exp_rx);
    last_w1 = w1;
    tick();
    expect_cycle("idle", 0, 0, 0, 0, 0, 0);
    chk8("idle.rx_data", rx_data_o, exp_rx);
  endtask

  initial begin
    vecs[0] = '{r0:1, r1:0, d0:8'hA5, d1:8'h00, md0:2'b00, md1:2'b11, dly:LONG_DLY, rx:8'h3C,
                drop:0, w1:0, md:8'hA5, pol:0, pha:0};
    vecs[1] = '{r0:1, r1:1, d0:8'h11, d1:8'h22, md0:2'b01, md1:2'b10, dly:2, rx:8'h5A,
                drop:0, w1:1, md:8'h22, pol:1, pha:0};
    vecs[2] = '{r0:1, r1:1, d0:8'h33, d1:8'h44, md0:2'b11, md1:2'b00, dly:0, rx:8'h0F,
                drop:0, w1:0, md:8'h33, pol:1, pha:1};
    vecs[3] = '{r0:1, r1:1, d0:8'h55, d1:8'h66, md0:2'b10, md1:2'b11, dly:3, rx:8'hF0,
                drop:0, w1:1, md:8'h66, pol:1, pha:1};
    vecs[4] = '{r0:0, r1:1, d0:8'hFF, d1:8'h77, md0:2'b11, md1:2'b01, dly:1, rx:8'h81,
                drop:0, w1:1, md:8'h77, pol:0, pha:1};
    vecs[5] = '{r0:1, r1:0, d0:8'h88, d1:8'hEE, md0:2'b00, md1:2'b10, dly:4, rx:8'h99,
                drop:1, w1:0, md:8'h88, pol:0, pha:0};

    reset_i = 1'b1;
    req0_i = 0; req1_i = 0; data0_i = 0; data1_i = 0; mode0_i = 0; mode1_i = 0;
    m_busy_i = 0; m_done_i = 0; m_rx_i = 0;
    tick();
    tick();
    chk_reset("reset");
    reset_i = 1'b0;
    tick();
    chk_reset("post_reset_idle");

    // Directed vector table
    foreach (vecs[k]) begin
      run_txn(vecs[k].r0, vecs[k].r1, vecs[k].d0, vecs[k].d1, vecs[k].md0, vecs[k].md1,
              vecs[k].w1, vecs[k].md, vecs[k].pol, vecs[k].pha,
              vecs[k].dly, vecs[k].rx, vecs[k].drop, 1'b0);
    end

    // Stray m_done in IDLE is ignored
    m_done_i = 1'b1; m_rx_i = 8'hEE;
    tick();
    m_done_i = 1'b0;
    expect_cycle("stray_done", 0, 0, 0, 0, 0, 0);
    chk8("stray_done.rx_data", rx_data_o, 8'h99);

    // Busy master holds off arbitration
    m_busy_i = 1'b1; req0_i = 1'b1; req1_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_cycle("busy_hold", 0, 0, 0, 0, 0, 0);
    end
    m_busy_i = 1'b0;
    run_txn(1, 0, 8'h4B, 8'h00, 2'b10, 2'b00, 0, 8'h4B, 1, 0, 1, 8'hB4, 1, 0);

    // Reset in the middle of WAIT, then a late m_done
    req0_i = 1'b0; req1_i = 1'b1; data1_i = 8'hC3; mode1_i = 2'b01;
    tick();
    expect_cycle("abort_setup", 0, 1, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    expect_cycle("abort_wait", 0, 1, 0, 0, 0, 0);
    req1_i = 1'b0;
    reset_i = 1'b1;
    #2;
    chk_reset("async_reset");
    tick();
    reset_i = 1'b0;
    m_done_i = 1'b1; m_rx_i = 8'h77;
    tick();
    m_done_i = 1'b0;
    chk_reset("late_done");
    exp_rx  = 8'h00;
    last_w1 = 1'b1;
    run_txn(1, 1, 8'h12, 8'h34, 2'b01, 2'b10, 0, 8'h12, 0, 1, 0, 8'h56, 0, 0);

`ifdef SPI_ARB_TIMEOUT_EN
    run_txn(1, 0, 8'h9A, 8'h00, 2'b11, 2'b00, 0, 8'h9A, 1, 1, 0, 8'h00, 1, 1);
    run_txn(1, 0, 8'h9B, 8'h00, 2'b01, 2'b00, 0, 8'h9B, 0, 1, TB_TO - 1, 8'h6D, 1, 0);
`else
    run_txn(1, 0, 8'h9A, 8'h00, 2'b11, 2'b00, 0, 8'h9A, 1, 1, 40, 8'h6D, 1, 0);
`endif

    // Randomized transactions against the round-robin model
    for (int t = 0; t < 40; t++) begin
      bit r0, r1, w1, drop;
      logic [7:0] d0, d1, rx;
      logic [1:0] md0, md1, mw;
      int nb;
      {r1, r0} = 2'($urandom_range(1, 3));
      d0 = 8'($urandom); d1 = 8'($urandom); rx = 8'($urandom);
      md0 = 2'($urandom); md1 = 2'($urandom);
      drop = 1'($urandom);
      if (r0 && r1) w1 = !last_w1;
      else          w1 = r1;
      mw = w1 ? md1 : md0;
      nb = $urandom_range(0, 2);
      if (nb > 0) begin
        req0_i = r0; req1_i = r1; m_busy_i = 1'b1;
        for (int i = 0; i < nb; i++) begin
          tick();
          expect_cycle("rnd_busy", 0, 0, 0, 0, 0, 0);
        end
        m_busy_i = 1'b0;
      end
      run_txn(r0, r1, d0, d1, md0, md1, w1, w1 ? d1 : d0, mw[1], mw[0],
              $urandom_range(0, 8), rx, drop, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, cycles allowed in WAIT before abort (1..255, 8-bit counter).
REQ-002 clk  input  1  single system clock; all logic on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0 / req1  input  1 each  requester transaction request, level.
REQ-005 data0 / data1  input  8 each  byte to transmit, per requester.
REQ-006 mode0 / mode1  input  2 each  {polarity, phase} SPI mode, per requester.
REQ-007 gnt0 / gnt1  output  1 each  requester owns the SPI master.
REQ-008 done0 / done1  output  1 each  one-cycle completion pulse to owning requester.
REQ-009 rx_data  output  8  byte received on MISO in the last completed transaction.
REQ-010 err  output  1  timeout flag, valid with the done pulse.
REQ-011 m_start  output  1  one-cycle start pulse to the SPI master.
REQ-012 m_data  output  8  byte presented to the SPI master data_wr.
REQ-013 m_polarity / m_phase  output  1 each  mode presented to the SPI master.
REQ-014 m_busy  input  1  SPI master is shifting or CS is low.
REQ-015 m_done  input  1  SPI master one-cycle end-of-byte pulse.
REQ-016 m_rx  input  8  SPI master received byte, valid with m_done.

Function
REQ-017 FSM states: IDLE, SETUP, START, WAIT, DONE; encoding is free.
REQ-018 IDLE: if m_busy=0 and any req is high, the arbiter selects a winner, latches its data and mode into internal registers, and moves to SETUP.
REQ-019 If m_busy=1, IDLE stays put and issues no grant.
REQ-020 Arbitration is round-robin: if one req is high, that requester wins; if both are high, the requester not served last wins.
REQ-021 A last_grant register updates in DONE.
REQ-022 SETUP: m_data, m_polarity and m_phase are driven from the latched registers, and hold stable from SETUP through DONE.
REQ-023 m_polarity and m_phase are settled one full cycle before m_start; SETUP then moves to START.
REQ-024 START: m_start=1 for exactly one cycle, then the FSM moves to WAIT.
REQ-025 Latency: m_start is high in the second cycle after the clock edge that samples req in IDLE.
REQ-026 WAIT: on m_done=1, m_rx is captured into rx_data and the FSM moves to DONE.
REQ-027 DONE lasts one cycle, pulses done0 or done1 for the winner and returns to IDLE.
REQ-028 gntX is high from SETUP through DONE inclusive and is low in IDLE.
REQ-029 gnt0 and gnt1 are never high together, and done0 and done1 are never high together.
REQ-030 A req deasserted after the grant is ignored; the transaction completes normally.
REQ-031 A req held high after done re-arbitrates in IDLE; when both requests are held high, grants alternate 0,1,0,1...
REQ-032 m_done outside WAIT is ignored.
REQ-033 rx_data holds its value until the next successful capture.

Reset
REQ-034 When reset is asserted, the FSM enters IDLE immediately and asynchronously.
REQ-035 Reset values: gnt0, gnt1, done0, done1, err, m_start, m_polarity, m_phase = 0; m_data, rx_data = 8'h00; timeout counter = 0.
REQ-036 last_grant resets to requester 1, so req0 wins the first tie.
REQ-037 Reset mid-transaction aborts it: no done pulse is produced, and an in-flight m_done is ignored.

Configuration
REQ-038 Macro SPI_ARB_TIMEOUT_EN.
REQ-039 With the macro defined, a counter clears on entry to WAIT and increments each WAIT cycle.
REQ-040 With the macro defined, if the count reaches TIMEOUT_CYCLES without m_done, the FSM moves to DONE with err=1 during the done pulse and rx_data unchanged.
REQ-041 With the macro defined, m_done in the same cycle as expiry takes priority (err=0, data captured).
REQ-042 With the macro defined, err is 0 in all cycles other than a timed-out done pulse.
REQ-043 Without the macro, WAIT waits indefinitely for m_done, err is tied to 0, the counter is not built and TIMEOUT_CYCLES is unused.

Verification
REQ-044 req0=1, data0=8'hA5, mode0=2'b00, m_done after 16 cycles with m_rx=8'h3C -> gnt0 high, m_data=8'hA5, one m_start pulse, done0 pulse, rx_data=8'h3C.
REQ-045 req0 and req1 held high across 4 transactions -> grant order 0,1,0,1, with each gnt high only SETUP..DONE.
REQ-046 req1=1, mode1=2'b11 -> m_polarity=1 and m_phase=1 one cycle before m_start; m_start exactly 2 cycles after req is sampled.
REQ-047 m_busy=1 with req0=1 -> no grant until m_busy falls, then SETUP on the next edge.
REQ-048 Reset pulsed during WAIT, then m_done -> all outputs at reset values, no done pulse, next tie goes to req0.
REQ-049 SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=10, m_done never arrives -> done0 with err=1 ten cycles after WAIT entry; repeat with m_done on cycle 10 -> err=0, data captured.
